// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-flop input synchroniser, mid-bit sampling deframer (8N1)
// and a first-word-fall-through byte FIFO with full/empty/overrun status.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 8,
  parameter int DATA_W       = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx,
  input  logic                     rd_en,
  input  logic                     clr_err,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     Rxff,
  output logic                     Fe,
  output logic                     done_r,
  output logic                     frame_err,
  output logic                     overrun,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_W);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_IDLE
  } state_e;

  state_e              state_q, state_d;
  logic                rx_meta_q, rx_s_q;
  logic [TW-1:0]       timer_q, timer_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                push, ferr_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q, count_d;
  logic                done_q, frame_err_q, overrun_q;
  logic                full, empty, pop, wr, ovf_set;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      frame_err_q <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    push    = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        idx_d   = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        // Re-check the line half a bit in; a high level here was only a glitch.
        if (timer_q == HALF_LAST) begin
          timer_d = '0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DATA: begin
        if (timer_q == BIT_LAST) begin
          timer_d        = '0;
          shift_d[idx_q] = rx_s_q;
          if (idx_q == IDX_LAST) state_d = S_STOP;
          else                   idx_d   = idx_q + IW'(1);
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_STOP: begin
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          if (rx_s_q) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_IDLE;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_WAIT_IDLE: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop     = rd_en & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign wr      = push & (~full | pop);
  assign ovf_set = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr_q] <= shift_q;
  end

  always_comb begin
    count_d = count_q;
    case ({wr, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (wr)  wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q   <= count_d;
      done_q    <= wr;
      overrun_q <= ovf_set | (overrun_q & ~clr_err);
    end
  end

  assign rd_data   = empty ? '0 : mem[rd_ptr_q];
  assign Rxff      = full;
  assign Fe        = empty;
  assign done_r    = done_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign count     = count_q;

endmodule
